// File: rtl/alu_bist.sv
// alu_bist: power-up self-test sequencer for the ALUControl + alu pair.
// Steps through an 11-entry R-type vector ROM. Each vector is launched onto the
// ALU operands, given SETTLE_CYCLES to propagate, then compared exactly with
// the stored result. The block reports pass/fail, a saturating failure count,
// and the index and ALU result of the first failing vector.
module alu_bist #(
    parameter int SETTLE_CYCLES = 1,   // 1..15
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [6:0]  Opcode,
    output logic [3:0]  FuncCode,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] ALUOut,
    input  logic        Branch_Enable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [3:0]  first_fail,
    output logic [31:0] fail_result
);

    localparam logic [6:0] OP_RTYPE    = 7'b0110011;
    localparam logic [3:0] LAST_IDX    = 4'd10;
    localparam logic [3:0] NO_FAIL     = 4'hF;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg;
    logic [3:0]  settle_cnt_reg;
    logic [3:0]  vec_func;
    logic [31:0] vec_a, vec_b, vec_exp;
    logic        accept, mismatch, run_end;

    // The branch flag is meaningless for R-type vectors, so it is never compared.
    logic unused_branch;
    assign unused_branch = Branch_Enable;

    // Vector ROM: operands and expected result for the current index.
    always_comb begin
        vec_func = 4'b0000;
        vec_a    = 32'd0;
        vec_b    = 32'd0;
        vec_exp  = 32'd0;
        case (idx_reg)
            4'd0:  begin vec_func = 4'b0111; vec_a = 32'h0F;   vec_b = 32'h55; vec_exp = 32'h05;        end
            4'd1:  begin vec_func = 4'b0110; vec_a = 32'h0F;   vec_b = 32'h55; vec_exp = 32'h5F;        end
            4'd2:  begin vec_func = 4'b0000; vec_a = 32'd10000; vec_b = 32'd111; vec_exp = 32'h0000_277F; end
            4'd3:  begin vec_func = 4'b1000; vec_a = 32'd10000; vec_b = 32'd111; vec_exp = 32'h0000_26A1; end
            4'd4:  begin vec_func = 4'b0010; vec_a = 32'd0;    vec_b = 32'd2;  vec_exp = 32'd1;         end
            4'd5:  begin vec_func = 4'b0101; vec_a = 32'd16;   vec_b = 32'd2;  vec_exp = 32'd4;         end
            4'd6:  begin vec_func = 4'b1101; vec_a = 32'd8;    vec_b = 32'd1;  vec_exp = 32'd4;         end
            4'd7:  begin vec_func = 4'b0001; vec_a = 32'd2;    vec_b = 32'd2;  vec_exp = 32'd8;         end
            4'd8:  begin vec_func = 4'b0100; vec_a = 32'h55;   vec_b = 32'hFF; vec_exp = 32'hAA;        end
            4'd9:  begin vec_func = 4'b0001; vec_a = 32'd2;    vec_b = 32'd16; vec_exp = 32'h0002_0000; end
            4'd10: begin vec_func = 4'b0001; vec_a = 32'd1;    vec_b = 32'd31; vec_exp = 32'h8000_0000; end
            default: ;
        endcase
    end

    // Run control qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept   = ((state_reg == IDLE) || (state_reg == DONE)) && start;
        mismatch = (state_reg == CHECK) && (ALUOut != vec_exp);
        run_end  = (idx_reg == LAST_IDX) || (mismatch && STOP_ON_FAIL);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = APPLY;
            APPLY:      state_next = SETTLE;
            SETTLE:     if (settle_cnt_reg == 4'd1) state_next = CHECK;
            CHECK:      state_next = run_end ? DONE : APPLY;
            default:    state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state; pass is only meaningful once done.
    always_comb begin
        busy = (state_reg == APPLY) || (state_reg == SETTLE) || (state_reg == CHECK);
        done = (state_reg == DONE);
        pass = done && (fail_count == 4'd0);
    end

    // Datapath: operand launch, settle timer, vector index and failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Opcode         <= 7'd0;
            FuncCode       <= 4'd0;
            A              <= 32'd0;
            B              <= 32'd0;
            idx_reg        <= 4'd0;
            settle_cnt_reg <= 4'd0;
            fail_count     <= 4'd0;
            first_fail     <= NO_FAIL;
            fail_result    <= 32'd0;
        end else begin
            if (accept) begin
                idx_reg     <= 4'd0;
                fail_count  <= 4'd0;
                first_fail  <= NO_FAIL;
                fail_result <= 32'd0;
            end
            if (state_reg == APPLY) begin
                Opcode         <= OP_RTYPE;
                FuncCode       <= vec_func;
                A              <= vec_a;
                B              <= vec_b;
                settle_cnt_reg <= SETTLE_LOAD;
            end
            if (state_reg == SETTLE) begin
                settle_cnt_reg <= settle_cnt_reg - 4'd1;
            end
            if (state_reg == CHECK) begin
                if (mismatch) begin
                    // A zero count means no earlier mismatch in this run.
                    if (fail_count == 4'd0) begin
                        first_fail  <= idx_reg;
                        fail_result <= ALUOut;
                    end
                    if (fail_count != 4'hF) begin
                        fail_count <= fail_count + 4'd1;
                    end
                end
                if (!run_end) begin
                    idx_reg <= idx_reg + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: three alu_bist instances (settle 1 / settle 1 stop-on-fail /
// settle 3), each wired to a behavioural ALU with per-vector fault masks and a
// stuck-at-ones mode. Expected results come from an arithmetic ALU model.
module tb_alu_bist;

    localparam int NDUT = 3;
    localparam int NVEC = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s  [NDUT];
    logic [6:0]  opcode_s [NDUT];
    logic [3:0]  func_s   [NDUT];
    logic [31:0] a_s      [NDUT];
    logic [31:0] b_s      [NDUT];
    logic        busy_s   [NDUT];
    logic        done_s   [NDUT];
    logic        pass_s   [NDUT];
    logic [3:0]  fc_s     [NDUT];
    logic [3:0]  ff_s     [NDUT];
    logic [31:0] fr_s     [NDUT];

    logic [31:0] fault_mask [NDUT][NVEC];
    bit          stuck      [NDUT];

    logic [3:0]  tv_func [NVEC] = '{4'b0111, 4'b0110, 4'b0000, 4'b1000, 4'b0010, 4'b0101,
                                    4'b1101, 4'b0001, 4'b0100, 4'b0001, 4'b0001};
    logic [31:0] tv_a    [NVEC] = '{32'h0F, 32'h0F, 32'd10000, 32'd10000, 32'd0, 32'd16,
                                    32'd8, 32'd2, 32'h55, 32'd2, 32'd1};
    logic [31:0] tv_b    [NVEC] = '{32'h55, 32'h55, 32'd111, 32'd111, 32'd2, 32'd2,
                                    32'd1, 32'd2, 32'hFF, 32'd16, 32'd31};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference RV32 R-type ALU selected by {instr[30], funct3}.
    function automatic logic [31:0] gold(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            logic [31:0] alu_out;
            logic        br_en;

            // Faulty-ALU model: golden result, corrupted for the vector whose operands are present.
            always_comb begin
                alu_out = (opcode_s[gi] == 7'b0110011) ? gold(func_s[gi], a_s[gi], b_s[gi]) : 32'd0;
                for (int i = 0; i < NVEC; i++) begin
                    if (func_s[gi] == tv_func[i] && a_s[gi] == tv_a[i] && b_s[gi] == tv_b[i])
                        alu_out = alu_out ^ fault_mask[gi][i];
                end
                if (stuck[gi]) alu_out = 32'hFFFF_FFFF;
                br_en = alu_out[0];
            end

            alu_bist #(
                .SETTLE_CYCLES ((gi == 2) ? 3 : 1),
                .STOP_ON_FAIL  (gi == 1)
            ) u_dut (
                .clk           (clk),
                .rst_n         (rst_n),
                .start         (start_s[gi]),
                .Opcode        (opcode_s[gi]),
                .FuncCode      (func_s[gi]),
                .A             (a_s[gi]),
                .B             (b_s[gi]),
                .ALUOut        (alu_out),
                .Branch_Enable (br_en),
                .busy          (busy_s[gi]),
                .done          (done_s[gi]),
                .pass          (pass_s[gi]),
                .fail_count    (fc_s[gi]),
                .first_fail    (ff_s[gi]),
                .fail_result   (fr_s[gi])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check_eq({tag, "_opcode"}, 32'(opcode_s[d]), 32'd0);
        check_eq({tag, "_func"},   32'(func_s[d]),   32'd0);
        check_eq({tag, "_a"},      a_s[d],           32'd0);
        check_eq({tag, "_b"},      b_s[d],           32'd0);
        check_eq({tag, "_busy"},   32'(busy_s[d]),   32'd0);
        check_eq({tag, "_done"},   32'(done_s[d]),   32'd0);
        check_eq({tag, "_pass"},   32'(pass_s[d]),   32'd0);
        check_eq({tag, "_fc"},     32'(fc_s[d]),     32'd0);
        check_eq({tag, "_ff"},     32'(ff_s[d]),     32'hF);
        check_eq({tag, "_fr"},     fr_s[d],          32'd0);
    endtask

    // One full run on instance d, predicted from the fault setup, then checked.
    task automatic run_once(input int d, input bit repulse);
        int          ns      = (d == 2) ? 3 : 1;
        bit          stop    = (d == 1);
        int          exp_fc  = 0;
        int          exp_ff  = 15;
        logic [31:0] exp_fr  = 32'd0;
        int          n_exec  = 0;
        int          last    = 0;
        int          cyc     = 0;
        int          done_err = 0;
        logic [31:0] got, want;

        for (int i = 0; i < NVEC; i++) begin
            want = gold(tv_func[i], tv_a[i], tv_b[i]);
            got  = stuck[d] ? 32'hFFFF_FFFF : (want ^ fault_mask[d][i]);
            n_exec++;
            last = i;
            if (got != want) begin
                if (exp_fc == 0) begin
                    exp_ff = i;
                    exp_fr = got;
                end
                if (exp_fc < 15) exp_fc++;
                if (stop) break;
            end
        end

        @(negedge clk) start_s[d] = 1'b1;
        @(negedge clk) start_s[d] = 1'b0;
        check_eq("start_busy",  32'(busy_s[d]), 32'd1);
        check_eq("start_done",  32'(done_s[d]), 32'd0);
        check_eq("start_fc",    32'(fc_s[d]),   32'd0);
        check_eq("start_ff",    32'(ff_s[d]),   32'hF);
        check_eq("start_fr",    fr_s[d],        32'd0);
        cyc = 1;
        for (int g = 0; g < 400; g++) begin
            if (done_s[d] || pass_s[d]) done_err++;
            @(negedge clk);
            if (!busy_s[d]) break;
            cyc++;
            if (repulse) start_s[d] = (cyc == 10);
        end
        start_s[d] = 1'b0;

        $display("run dut%0d: cycles=%0d fc=%0d ff=%0d fr=0x%08h (model cycles=%0d fc=%0d ff=%0d fr=0x%08h)",
                 d, cyc, fc_s[d], ff_s[d], fr_s[d], n_exec * (2 + ns), exp_fc, exp_ff, exp_fr);
        check_eq("run_cycles",     32'(cyc),          32'(n_exec * (2 + ns)));
        check_eq("done_low_busy",  32'(done_err),     32'd0);
        check_eq("end_done",       32'(done_s[d]),    32'd1);
        check_eq("end_pass",       32'(pass_s[d]),    32'(exp_fc == 0));
        check_eq("end_fail_count", 32'(fc_s[d]),      32'(exp_fc));
        check_eq("end_first_fail", 32'(ff_s[d]),      32'(exp_ff));
        check_eq("end_fail_result", fr_s[d],          exp_fr);
        check_eq("end_opcode",     32'(opcode_s[d]),  32'h33);
        check_eq("end_func",       32'(func_s[d]),    32'(tv_func[last]));
        check_eq("end_a",          a_s[d],            tv_a[last]);
        check_eq("end_b",          b_s[d],            tv_b[last]);
    endtask

    task automatic clear_faults();
        for (int d = 0; d < NDUT; d++) begin
            stuck[d] = 1'b0;
            for (int i = 0; i < NVEC; i++) fault_mask[d][i] = 32'd0;
        end
    endtask

    task automatic randomize_faults(input int d);
        logic [31:0] m;
        for (int i = 0; i < NVEC; i++) begin
            m = 32'd0;
            if ($urandom_range(3) == 0) begin
                m = $urandom;
                if (m == 32'd0) m = 32'd1;
            end
            fault_mask[d][i] = m;
        end
        stuck[d] = ($urandom_range(7) == 0);
    endtask

    initial begin
        bit found;
        int d;
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) start_s[k] = 1'b0;
        clear_faults();

        #12;
        for (int k = 0; k < NDUT; k++) check_reset_state(k, "reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) check_reset_state(k, "post_reset");

        // Golden ALU.
        run_once(0, 1'b0);

        // Vector 3 result forced to zero.
        fault_mask[0][3] = gold(tv_func[3], tv_a[3], tv_b[3]);
        run_once(0, 1'b0);
        clear_faults();

        // Stuck-at-ones ALU, with and without stop-on-fail.
        stuck[0] = 1'b1;
        run_once(0, 1'b0);
        stuck[1] = 1'b1;
        run_once(1, 1'b0);
        clear_faults();

        // Reset asserted during vector 5 settle abandons the run.
        @(negedge clk) start_s[0] = 1'b1;
        @(negedge clk) start_s[0] = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (func_s[0] == 4'b0101 && a_s[0] == 32'd16) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("reach_vec5", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_state(0, "midrun_reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_state(0, "no_resume");
        run_once(0, 1'b0);

        // Slow settle, start re-pulsed while busy, then restart from DONE.
        randomize_faults(2);
        stuck[2] = 1'b0;
        fault_mask[2][0] = 32'h0000_0100;
        run_once(2, 1'b1);
        clear_faults();
        run_once(2, 1'b0);

        // Randomized fault patterns across all instances.
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(NDUT - 1);
            randomize_faults(d);
            run_once(d, ($urandom_range(1) == 1));
            clear_faults();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
